// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Control FSM for a five-phase multicycle MIPS-subset datapath
//               (R add/sub, lw, sw, beq, j). Phases IF/ID/EX/MEM/WB are
//               presented one-hot. Op/IRFunc are captured in ID, and later
//               phases use only the captured copy.
//               Optional macro CTRL_ILLEGAL_TRAP_EN: an illegal instruction
//               enters a sticky TRAP state. Without the macro, an illegal
//               instruction retires as a two-cycle NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
    input  logic       clk,
    input  logic       clr,
    input  logic [5:0] Op,
    input  logic [5:0] IRFunc,
    input  logic       Zero,
    input  logic       MemRdy,
    output logic       P0,
    output logic       P1,
    output logic       P2,
    output logic       P3,
    output logic       P4,
    output logic       P,
    output logic [5:0] Func,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemRd,
    output logic       MemWr,
    output logic       RegDst,
    output logic       MemToReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       Trap
);

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_FN_ADD  = 6'b100000;
    localparam logic [5:0] c_FN_SUB  = 6'b100010;

`ifdef CTRL_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;
`else
    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;
`endif

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;
    logic [5:0] r_func;

    // Live decode, used only in ID to pick the transition
    logic w_id_rtype, w_id_legal, w_id_j;
    // Decode of the captured instruction, used in EX/MEM/WB
    logic w_is_r, w_is_lw, w_is_sw, w_is_beq;

    // Raw strobes before reset gating
    logic w_pcwr, w_irwr, w_regwr, w_memwr, w_p, w_trap;

    assign w_id_rtype = (Op == c_OP_R) && ((IRFunc == c_FN_ADD) || (IRFunc == c_FN_SUB));
    assign w_id_j     = (Op == c_OP_J);
    assign w_id_legal = w_id_rtype || w_id_j || (Op == c_OP_LW) ||
                        (Op == c_OP_SW) || (Op == c_OP_BEQ);

    assign w_is_r   = (r_op == c_OP_R);
    assign w_is_lw  = (r_op == c_OP_LW);
    assign w_is_sw  = (r_op == c_OP_SW);
    assign w_is_beq = (r_op == c_OP_BEQ);

    // State register and instruction-field capture; clr wins over everything
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IF;
            r_op    <= 6'b000000;
            r_func  <= 6'b000000;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID) begin
                r_op   <= Op;
                r_func <= IRFunc;
            end
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next   = r_state;
        w_p      = 1'b0;
        w_trap   = 1'b0;
        Func     = c_FN_ADD;
        w_pcwr   = 1'b0;
        w_irwr   = 1'b0;
        w_regwr  = 1'b0;
        MemRd    = 1'b0;
        w_memwr  = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        case (r_state)
            S_IF: begin
                MemRd   = 1'b1;
                ALUSrcB = 2'b01;
                if (MemRdy) begin
                    w_irwr = 1'b1;
                    w_pcwr = 1'b1;
                    w_next = S_ID;
                end
            end
            S_ID: begin
                // Branch target is precomputed here while decoding
                ALUSrcB = 2'b10;
                if (w_id_j) begin
                    w_pcwr = 1'b1;
                    PCSrc  = 2'b10;
                    w_p    = 1'b1;
                    w_next = S_IF;
                end else if (w_id_legal) begin
                    w_next = S_EX;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_p    = 1'b1;
                    w_next = S_IF;
`endif
                end
            end
            S_EX: begin
                if (w_is_r) begin
                    Func   = r_func;
                    w_next = S_WB;
                end else if (w_is_beq) begin
                    Func   = c_FN_SUB;
                    PCSrc  = 2'b01;
                    w_pcwr = Zero;
                    w_p    = 1'b1;
                    w_next = S_IF;
                end else begin
                    ALUSrcB = 2'b10;
                    w_next  = S_MEM;
                end
            end
            S_MEM: begin
                MemRd   = w_is_lw;
                w_memwr = w_is_sw;
                if (MemRdy) begin
                    w_p    = w_is_sw;
                    w_next = w_is_lw ? S_WB : S_IF;
                end
            end
            S_WB: begin
                w_regwr  = 1'b1;
                RegDst   = w_is_r;
                MemToReg = w_is_lw;
                w_p      = 1'b1;
                w_next   = S_IF;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_trap = 1'b1;
            end
`endif
            default: begin
                w_next = S_IF;
            end
        endcase
    end

    // An edge with clr high must not commit any write of the interrupted instruction
    assign PCWr  = w_pcwr  & ~clr;
    assign IRWr  = w_irwr  & ~clr;
    assign RegWr = w_regwr & ~clr;
    assign MemWr = w_memwr & ~clr;
    assign P     = w_p     & ~clr;
    assign Trap  = w_trap  & ~clr;

    assign P0 = (r_state == S_IF);
    assign P1 = (r_state == S_ID);
    assign P2 = (r_state == S_EX);
    assign P3 = (r_state == S_MEM);
    assign P4 = (r_state == S_WB);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Scoreboard bench for multicycle_ctrl. Each stimulus cycle
//               pushes its expected output vector. A monitor on the falling
//               edge pops the vector and compares it with the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [5:0] Op, IRFunc;
    logic       Zero, MemRdy;
    logic       P0, P1, P2, P3, P4, P;
    logic [5:0] Func;
    logic       PCWr, IRWr, RegWr, MemRd, MemWr, RegDst, MemToReg;
    logic [1:0] ALUSrcB, PCSrc;
    logic       Trap;

    int n_total = 0;
    int n_pass  = 0;

    logic [23:0] q_exp[$];
    string       q_name[$];

    always #5 clk = ~clk;

    multicycle_ctrl u_dut (
        .clk(clk), .clr(clr), .Op(Op), .IRFunc(IRFunc), .Zero(Zero), .MemRdy(MemRdy),
        .P0(P0), .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P(P), .Func(Func),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemRd(MemRd), .MemWr(MemWr),
        .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .Trap(Trap)
    );

    localparam logic [4:0] PH_IF  = 5'b10000;
    localparam logic [4:0] PH_ID  = 5'b01000;
    localparam logic [4:0] PH_EX  = 5'b00100;
    localparam logic [4:0] PH_MEM = 5'b00010;
    localparam logic [4:0] PH_WB  = 5'b00001;
    localparam logic [5:0] ADD    = 6'b100000;
    localparam logic [5:0] SUB    = 6'b100010;

    // Expected vector layout: {phases, P, Func, strobes, ALUSrcB, PCSrc, Trap}
    // strobes = {PCWr, IRWr, RegWr, MemRd, MemWr, RegDst, MemToReg}
    function automatic logic [23:0] ev(input logic [4:0] ph, input logic p,
                                       input logic [5:0] fn, input logic [6:0] st,
                                       input logic [1:0] sb, input logic [1:0] ps,
                                       input logic tr);
        return {ph, p, fn, st, sb, ps, tr};
    endfunction

    // Monitor: compare the DUT against the oldest expected vector
    always @(negedge clk) begin
        logic [23:0] e, a;
        string       nm;
        if (q_exp.size() > 0) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            a  = {P0, P1, P2, P3, P4, P, Func, PCWr, IRWr, RegWr, MemRd, MemWr,
                  RegDst, MemToReg, ALUSrcB, PCSrc, Trap};
            n_total++;
            if (a === e) n_pass++;
            else $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    end

    task automatic cyc(input string nm, input logic c, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, input logic r,
                       input logic [23:0] e);
        clr = c; Op = op; IRFunc = fn; Zero = z; MemRdy = r;
        q_exp.push_back(e);
        q_name.push_back(nm);
        @(posedge clk); #1;
    endtask

    logic [23:0] e_if_w, e_if_r, e_id, e_id_j, e_id_nop, e_ex_add, e_ex_sub, e_ex_mem;
    logic [23:0] e_ex_beq1, e_ex_beq0, e_mem_lw, e_mem_sw_w, e_mem_sw_r, e_mem_clr;
    logic [23:0] e_wb_r, e_wb_lw, e_trap, e_trap_clr;

    initial begin
        e_if_w     = ev(PH_IF,  1'b0, ADD, 7'b0001000, 2'b01, 2'b00, 1'b0);
        e_if_r     = ev(PH_IF,  1'b0, ADD, 7'b1101000, 2'b01, 2'b00, 1'b0);
        e_id       = ev(PH_ID,  1'b0, ADD, 7'b0000000, 2'b10, 2'b00, 1'b0);
        e_id_j     = ev(PH_ID,  1'b1, ADD, 7'b1000000, 2'b10, 2'b10, 1'b0);
        e_id_nop   = ev(PH_ID,  1'b1, ADD, 7'b0000000, 2'b10, 2'b00, 1'b0);
        e_ex_add   = ev(PH_EX,  1'b0, ADD, 7'b0000000, 2'b00, 2'b00, 1'b0);
        e_ex_sub   = ev(PH_EX,  1'b0, SUB, 7'b0000000, 2'b00, 2'b00, 1'b0);
        e_ex_mem   = ev(PH_EX,  1'b0, ADD, 7'b0000000, 2'b10, 2'b00, 1'b0);
        e_ex_beq1  = ev(PH_EX,  1'b1, SUB, 7'b1000000, 2'b00, 2'b01, 1'b0);
        e_ex_beq0  = ev(PH_EX,  1'b1, SUB, 7'b0000000, 2'b00, 2'b01, 1'b0);
        e_mem_lw   = ev(PH_MEM, 1'b0, ADD, 7'b0001000, 2'b00, 2'b00, 1'b0);
        e_mem_sw_w = ev(PH_MEM, 1'b0, ADD, 7'b0000100, 2'b00, 2'b00, 1'b0);
        e_mem_sw_r = ev(PH_MEM, 1'b1, ADD, 7'b0000100, 2'b00, 2'b00, 1'b0);
        e_mem_clr  = ev(PH_MEM, 1'b0, ADD, 7'b0000000, 2'b00, 2'b00, 1'b0);
        e_wb_r     = ev(PH_WB,  1'b1, ADD, 7'b0010010, 2'b00, 2'b00, 1'b0);
        e_wb_lw    = ev(PH_WB,  1'b1, ADD, 7'b0010001, 2'b00, 2'b00, 1'b0);
        e_trap     = ev(5'b0,   1'b0, ADD, 7'b0000000, 2'b00, 2'b00, 1'b1);
        e_trap_clr = ev(5'b0,   1'b0, ADD, 7'b0000000, 2'b00, 2'b00, 1'b0);

        clr = 1'b1; Op = 6'b0; IRFunc = 6'b0; Zero = 1'b0; MemRdy = 1'b1;
        @(posedge clk); #1;
        // Second reset cycle in IF with MemRdy=1: no IR/PC write may leak
        cyc("rst_if",     1'b1, 6'b000000, ADD, 1'b0, 1'b1, e_if_w);

        // R add; Op/IRFunc change after ID must not disturb EX/WB
        cyc("add_if",     1'b0, 6'b000000, ADD, 1'b0, 1'b1, e_if_r);
        cyc("add_id",     1'b0, 6'b000000, ADD, 1'b0, 1'b1, e_id);
        cyc("add_ex",     1'b0, 6'b111111, SUB, 1'b0, 1'b1, e_ex_add);
        cyc("add_wb",     1'b0, 6'b100011, SUB, 1'b0, 1'b1, e_wb_r);

        // R sub
        cyc("sub_if",     1'b0, 6'b000000, SUB, 1'b0, 1'b1, e_if_r);
        cyc("sub_id",     1'b0, 6'b000000, SUB, 1'b0, 1'b1, e_id);
        cyc("sub_ex",     1'b0, 6'b000000, ADD, 1'b0, 1'b1, e_ex_sub);
        cyc("sub_wb",     1'b0, 6'b000000, ADD, 1'b0, 1'b1, e_wb_r);

        // lw with three memory wait cycles in MEM: 8 cycles total
        cyc("lw_if",      1'b0, 6'b100011, 6'b0, 1'b0, 1'b1, e_if_r);
        cyc("lw_id",      1'b0, 6'b100011, 6'b0, 1'b0, 1'b1, e_id);
        cyc("lw_ex",      1'b0, 6'b100011, 6'b0, 1'b0, 1'b1, e_ex_mem);
        for (int i = 0; i < 3; i++)
            cyc("lw_mem_wait", 1'b0, 6'b100011, 6'b0, 1'b0, 1'b0, e_mem_lw);
        cyc("lw_mem_rdy", 1'b0, 6'b100011, 6'b0, 1'b0, 1'b1, e_mem_lw);
        cyc("lw_wb",      1'b0, 6'b100011, 6'b0, 1'b0, 1'b1, e_wb_lw);

        // sw with one fetch wait cycle
        cyc("sw_if_wait", 1'b0, 6'b101011, 6'b0, 1'b0, 1'b0, e_if_w);
        cyc("sw_if",      1'b0, 6'b101011, 6'b0, 1'b0, 1'b1, e_if_r);
        cyc("sw_id",      1'b0, 6'b101011, 6'b0, 1'b0, 1'b1, e_id);
        cyc("sw_ex",      1'b0, 6'b101011, 6'b0, 1'b0, 1'b1, e_ex_mem);
        cyc("sw_mem_wait",1'b0, 6'b101011, 6'b0, 1'b0, 1'b0, e_mem_sw_w);
        cyc("sw_mem",     1'b0, 6'b101011, 6'b0, 1'b0, 1'b1, e_mem_sw_r);

        // beq taken then not taken
        cyc("beq1_if",    1'b0, 6'b000100, 6'b0, 1'b0, 1'b1, e_if_r);
        cyc("beq1_id",    1'b0, 6'b000100, 6'b0, 1'b0, 1'b1, e_id);
        cyc("beq1_ex",    1'b0, 6'b000100, 6'b0, 1'b1, 1'b1, e_ex_beq1);
        cyc("beq0_if",    1'b0, 6'b000100, 6'b0, 1'b0, 1'b1, e_if_r);
        cyc("beq0_id",    1'b0, 6'b000100, 6'b0, 1'b0, 1'b1, e_id);
        cyc("beq0_ex",    1'b0, 6'b000100, 6'b0, 1'b0, 1'b1, e_ex_beq0);

        // j retires in ID
        cyc("j_if",       1'b0, 6'b000010, 6'b0, 1'b0, 1'b1, e_if_r);
        cyc("j_id",       1'b0, 6'b000010, 6'b0, 1'b0, 1'b1, e_id_j);

        // Illegal R-type function, then illegal opcode
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc("ilf_if",     1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1, e_if_r);
        cyc("ilf_id",     1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1, e_id);
        cyc("ilf_trap",   1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1, e_trap);
        cyc("ilf_clr",    1'b1, 6'b000000, 6'b000000, 1'b0, 1'b1, e_trap_clr);
        cyc("ilo_if",     1'b0, 6'b111111, 6'b0, 1'b0, 1'b1, e_if_r);
        cyc("ilo_id",     1'b0, 6'b111111, 6'b0, 1'b0, 1'b1, e_id);
        for (int i = 0; i < 3; i++)
            cyc("ilo_trap", 1'b0, 6'b000000, ADD, 1'b0, 1'b1, e_trap);
        cyc("ilo_clr",    1'b1, 6'b000000, ADD, 1'b0, 1'b1, e_trap_clr);
`else
        cyc("ilf_if",     1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1, e_if_r);
        cyc("ilf_id",     1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1, e_id_nop);
        cyc("ilo_if",     1'b0, 6'b111111, 6'b0, 1'b0, 1'b1, e_if_r);
        cyc("ilo_id",     1'b0, 6'b111111, 6'b0, 1'b0, 1'b1, e_id_nop);
`endif

        // sw interrupted by clr in MEM while MemRdy=1: no write, back to IF
        cyc("swc_if",     1'b0, 6'b101011, 6'b0, 1'b0, 1'b1, e_if_r);
        cyc("swc_id",     1'b0, 6'b101011, 6'b0, 1'b0, 1'b1, e_id);
        cyc("swc_ex",     1'b0, 6'b101011, 6'b0, 1'b0, 1'b1, e_ex_mem);
        cyc("swc_mem_clr",1'b1, 6'b101011, 6'b0, 1'b0, 1'b1, e_mem_clr);
        cyc("swc_after",  1'b0, 6'b101011, 6'b0, 1'b0, 1'b0, e_if_w);

        // Every pushed expectation must have been consumed by the monitor
        @(negedge clk); #1;
        n_total++;
        if (q_exp.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", q_exp.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
